wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Purpose : merges results from FU_NUMBER functional units into two writeback ports,
//           buffering each FU in its own 2-entry FIFO and granting round-robin.
// Latency : 1 cycle from accept to writeback (0 cycles via bypass when WB_ARBITER_BYPASS_EN is defined).
// Backpr. : fu_ready[i] drops while FIFO i is full; the FU must hold its result until ready returns.
//
// Ports
//   clk                        single clock
//   rst_n                      reset, asynchronous and ACTIVE-HIGH despite the name
//   flush                      discards every buffered result and restarts round-robin at FU0
//   fu_valid/dest/data/ticket  per-FU result, flattened FU-major ({FU3..FU0})
//   fu_ready                   per-FU "FIFO can accept" (registered count only)
//   wb_valid/dest/data/ticket  two writeback ports, port 0 in the low slice
// Optional feature macro: WB_ARBITER_BYPASS_EN (empty FIFO + valid input may be granted same cycle).
module wb_arbiter #(
    parameter int FU_NUMBER      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int R_ADDR         = 6,
    parameter int ROB_INDEX_BITS = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic [FU_NUMBER-1:0]                fu_valid,
    input  logic [FU_NUMBER*R_ADDR-1:0]         fu_dest,
    input  logic [FU_NUMBER*DATA_WIDTH-1:0]     fu_data,
    input  logic [FU_NUMBER*ROB_INDEX_BITS-1:0] fu_ticket,
    output logic [FU_NUMBER-1:0]                fu_ready,
    output logic [1:0]                          wb_valid,
    output logic [2*R_ADDR-1:0]                 wb_dest,
    output logic [2*DATA_WIDTH-1:0]             wb_data,
    output logic [2*ROB_INDEX_BITS-1:0]         wb_ticket
);
    localparam int EW = R_ADDR + DATA_WIDTH + ROB_INDEX_BITS;
    localparam int PW = (FU_NUMBER > 1) ? $clog2(FU_NUMBER) : 1;

    // Per-FU FIFO state: entries packed as {dest, data, ticket}.
    logic [EW-1:0]        r_mem [FU_NUMBER][2];
    logic [FU_NUMBER-1:0] r_wp;
    logic [FU_NUMBER-1:0] r_rp;
    logic [1:0]           r_cnt [FU_NUMBER];
    logic [PW-1:0]        r_rr_ptr;

    logic [EW-1:0]        w_in   [FU_NUMBER];
    logic [EW-1:0]        w_src  [FU_NUMBER];
    logic [FU_NUMBER-1:0] w_elig;
    logic [FU_NUMBER-1:0] w_grant;
    logic [FU_NUMBER-1:0] w_push;
    logic [FU_NUMBER-1:0] w_pop;
    logic [1:0]           w_g_vld;
    logic [PW-1:0]        w_g_idx [2];
    logic [PW-1:0]        w_last;
    logic [PW:0]          w_sum;
    logic [PW-1:0]        w_idx;
    logic [PW:0]          w_rr_sum;
    logic [PW-1:0]        w_rr_nxt;

    // Per-FU input packing, head selection and eligibility.
    always_comb begin
        for (int i = 0; i < FU_NUMBER; i++) begin
            w_in[i] = {fu_dest[i*R_ADDR +: R_ADDR],
                       fu_data[i*DATA_WIDTH +: DATA_WIDTH],
                       fu_ticket[i*ROB_INDEX_BITS +: ROB_INDEX_BITS]};
            // An empty FIFO can only be granted through the bypass, so its source is the live input.
            w_src[i]    = (r_cnt[i] == 2'd0) ? w_in[i] : r_mem[i][r_rp[i]];
            fu_ready[i] = (r_cnt[i] < 2'd2);
`ifdef WB_ARBITER_BYPASS_EN
            w_elig[i]   = !rst_n && !flush && ((r_cnt[i] != 2'd0) || fu_valid[i]);
`else
            w_elig[i]   = !rst_n && !flush && (r_cnt[i] != 2'd0);
`endif
        end
    end

    // Round-robin search from r_rr_ptr; first hit goes to port 0, second to port 1.
    always_comb begin
        w_grant    = '0;
        w_g_vld    = '0;
        w_g_idx[0] = '0;
        w_g_idx[1] = '0;
        w_last     = r_rr_ptr;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = 0; k < FU_NUMBER; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(FU_NUMBER)) begin
                w_sum = w_sum - (PW+1)'(FU_NUMBER);
            end
            w_idx = w_sum[PW-1:0];
            if (w_elig[w_idx] && !w_g_vld[1]) begin
                if (!w_g_vld[0]) begin
                    w_g_vld[0] = 1'b1;
                    w_g_idx[0] = w_idx;
                end else begin
                    w_g_vld[1] = 1'b1;
                    w_g_idx[1] = w_idx;
                end
                w_grant[w_idx] = 1'b1;
                w_last         = w_idx;
            end
        end
    end

    // Pointer restarts just after the last FU served this cycle.
    always_comb begin
        w_rr_sum = {1'b0, w_last} + (PW+1)'(1);
        w_rr_nxt = (w_rr_sum >= (PW+1)'(FU_NUMBER)) ? '0 : w_rr_sum[PW-1:0];
    end

    always_comb begin
        for (int i = 0; i < FU_NUMBER; i++) begin
            w_pop[i]  = w_grant[i] && (r_cnt[i] != 2'd0);
            // A bypassed result (granted while empty) is consumed directly and never stored.
            w_push[i] = fu_valid[i] && fu_ready[i] && !flush &&
                        !(w_grant[i] && (r_cnt[i] == 2'd0));
        end
    end

    always_comb begin
        wb_valid  = w_g_vld;
        wb_dest   = '0;
        wb_data   = '0;
        wb_ticket = '0;
        for (int p = 0; p < 2; p++) begin
            if (w_g_vld[p]) begin
                {wb_dest[p*R_ADDR +: R_ADDR],
                 wb_data[p*DATA_WIDTH +: DATA_WIDTH],
                 wb_ticket[p*ROB_INDEX_BITS +: ROB_INDEX_BITS]} = w_src[w_g_idx[p]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_rr_ptr <= '0;
            for (int i = 0; i < FU_NUMBER; i++) r_cnt[i] <= 2'd0;
        end else if (flush) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_rr_ptr <= '0;
            for (int i = 0; i < FU_NUMBER; i++) r_cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < FU_NUMBER; i++) begin
                if (w_push[i]) r_wp[i] <= ~r_wp[i];
                if (w_pop[i])  r_rp[i] <= ~r_rp[i];
                r_cnt[i] <= r_cnt[i] + {1'b0, w_push[i]} - {1'b0, w_pop[i]};
            end
            if (|w_g_vld) r_rr_ptr <= w_rr_nxt;
        end
    end

    // Storage needs no reset: counts gate every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FU_NUMBER; i++) begin
            if (w_push[i]) r_mem[i][r_wp[i]] <= w_in[i];
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
`timescale 1ns/1ps
module tb_wb_arbiter;
    localparam int FUN = 4;
    localparam int DW  = 32;
    localparam int RA  = 6;
    localparam int TB  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              flush = 1'b0;
    logic [FUN-1:0]    fu_valid = '0;
    logic [FUN*RA-1:0] fu_dest = '0;
    logic [FUN*DW-1:0] fu_data = '0;
    logic [FUN*TB-1:0] fu_ticket = '0;
    logic [FUN-1:0]    fu_ready;
    logic [1:0]        wb_valid;
    logic [2*RA-1:0]   wb_dest;
    logic [2*DW-1:0]   wb_data;
    logic [2*TB-1:0]   wb_ticket;

    int checks = 0;
    int failures = 0;

    wb_arbiter #(.FU_NUMBER(FUN), .DATA_WIDTH(DW), .R_ADDR(RA), .ROB_INDEX_BITS(TB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fu_valid(fu_valid), .fu_dest(fu_dest), .fu_data(fu_data), .fu_ticket(fu_ticket),
        .fu_ready(fu_ready),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_ticket(wb_ticket)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled 3ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drive(input int i, input logic [RA-1:0] d, input logic [DW-1:0] x,
                         input logic [TB-1:0] t);
        fu_valid[i]           = 1'b1;
        fu_dest[i*RA +: RA]   = d;
        fu_data[i*DW +: DW]   = x;
        fu_ticket[i*TB +: TB] = t;
    endtask

    task automatic idle;
        fu_valid = '0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < FUN; i++) drive(i, RA'(i + 1), 32'hC0DE_0000 + i, TB'(i));
        repeat (3) begin
            tick;
            settle;
            checks++;
            if (wb_valid !== 2'b00) begin
                failures++; $display("FAIL reset_wb_valid got=%b exp=00", wb_valid);
            end
            checks++;
            if (fu_ready !== 4'b1111) begin
                failures++; $display("FAIL reset_fu_ready got=%b exp=1111", fu_ready);
            end
            checks++;
            if (wb_data !== '0 || wb_dest !== '0 || wb_ticket !== '0) begin
                failures++; $display("FAIL reset_wb_zero data=%h dest=%h ticket=%h", wb_data, wb_dest, wb_ticket);
            end
        end
        tick;
        idle;
        rst_n = 1'b0;
        settle;
        checks++;
        if (dut.r_rr_ptr !== 2'd0) begin
            failures++; $display("FAIL reset_rr_ptr got=%0d exp=0", dut.r_rr_ptr);
        end
        tick;
        settle;
        checks++;
        if (wb_valid !== 2'b00) begin
            failures++; $display("FAIL reset_nothing_captured got=%b exp=00", wb_valid);
        end
    endtask

    task automatic test_all_four;
        tick;
        for (int i = 0; i < FUN; i++) drive(i, RA'(10 + i), 32'hA5A5_0000 + i, TB'(i));
        settle;
        checks++;
        if (wb_valid !== 2'b00) begin
            failures++; $display("FAIL all4_accept_cycle got=%b exp=00", wb_valid);
        end
        tick;
        idle;
        settle;
        checks++;
        if (wb_valid !== 2'b11 || wb_data[31:0] !== 32'hA5A5_0000 || wb_data[63:32] !== 32'hA5A5_0001) begin
            failures++; $display("FAIL all4_first vld=%b data=%h exp vld=11 data=a5a50001a5a50000", wb_valid, wb_data);
        end
        checks++;
        if (wb_dest !== {6'd11, 6'd10} || wb_ticket !== {3'd1, 3'd0}) begin
            failures++; $display("FAIL all4_first_tag dest=%h ticket=%h exp dest=2ca ticket=08", wb_dest, wb_ticket);
        end
        tick;
        settle;
        checks++;
        if (wb_valid !== 2'b11 || wb_data[31:0] !== 32'hA5A5_0002 || wb_data[63:32] !== 32'hA5A5_0003) begin
            failures++; $display("FAIL all4_second vld=%b data=%h exp vld=11 data=a5a50003a5a50002", wb_valid, wb_data);
        end
        tick;
        settle;
        checks++;
        if (wb_valid !== 2'b00) begin
            failures++; $display("FAIL all4_drained got=%b exp=00", wb_valid);
        end
        checks++;
        if (dut.r_rr_ptr !== 2'd0) begin
            failures++; $display("FAIL all4_rr_ptr got=%0d exp=0", dut.r_rr_ptr);
        end
    endtask

    // FU0 and FU1 stream every cycle; FU3 sends D0..D2 and must hold D2 for one cycle.
    task automatic test_backpressure;
        logic [1:0]  e_vld [0:6];
        logic [31:0] e_p0  [0:6];
        logic [31:0] e_p1  [0:6];
        logic        e_rdy3[0:6];
        int          d3k   [0:3];
        e_vld  = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        e_p0   = '{32'h0, 32'hA000_0000, 32'hD000_0000, 32'hB000_0001,
                   32'hA000_0002, 32'hD000_0002, 32'h0};
        e_p1   = '{32'h0, 32'hB000_0000, 32'hA000_0001, 32'hD000_0001,
                   32'hB000_0002, 32'hA000_0003, 32'h0};
        e_rdy3 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        d3k    = '{0, 1, 2, 2};
        for (int c = 0; c < 7; c++) begin
            tick;
            idle;
            if (c < 4) drive(0, RA'(0), 32'hA000_0000 + c, TB'(c));
            if (c < 3) drive(1, RA'(1), 32'hB000_0000 + c, TB'(c));
            if (c < 4) drive(3, RA'(3), 32'hD000_0000 + d3k[c], TB'(d3k[c]));
            settle;
            checks++;
            if (wb_valid !== e_vld[c] || wb_data[31:0] !== e_p0[c] || wb_data[63:32] !== e_p1[c]) begin
                failures++;
                $display("FAIL bp_cycle%0d vld=%b p0=%h p1=%h exp vld=%b p0=%h p1=%h",
                         c, wb_valid, wb_data[31:0], wb_data[63:32], e_vld[c], e_p0[c], e_p1[c]);
            end
            checks++;
            if (fu_ready[3] !== e_rdy3[c]) begin
                failures++; $display("FAIL bp_ready3_cycle%0d got=%b exp=%b", c, fu_ready[3], e_rdy3[c]);
            end
        end
        idle;
    endtask

    task automatic test_single;
        tick;
        idle;
        drive(2, 6'd5, 32'hDEAD_BEEF, 3'd3);
        settle;
        checks++;
        if (wb_valid !== 2'b00) begin
            failures++; $display("FAIL single_accept_cycle got=%b exp=00", wb_valid);
        end
        tick;
        idle;
        settle;
        checks++;
        if (wb_valid !== 2'b01 || wb_dest[5:0] !== 6'd5 || wb_data[31:0] !== 32'hDEAD_BEEF || wb_ticket[2:0] !== 3'd3) begin
            failures++;
            $display("FAIL single_port0 vld=%b dest=%0d data=%h ticket=%0d exp vld=01 dest=5 data=deadbeef ticket=3",
                     wb_valid, wb_dest[5:0], wb_data[31:0], wb_ticket[2:0]);
        end
        checks++;
        if (wb_dest[11:6] !== 6'd0 || wb_data[63:32] !== 32'd0 || wb_ticket[5:3] !== 3'd0) begin
            failures++; $display("FAIL single_port1_zero dest=%h data=%h ticket=%h", wb_dest[11:6], wb_data[63:32], wb_ticket[5:3]);
        end
        tick;
        settle;
        checks++;
        if (wb_valid !== 2'b00) begin
            failures++; $display("FAIL single_popped got=%b exp=00", wb_valid);
        end
    endtask

    task automatic test_push_pop;
        tick;
        idle;
        drive(1, 6'd7, 32'h1111_0000, 3'd0);
        settle;
        for (int k = 1; k <= 4; k++) begin
            tick;
            idle;
            drive(1, 6'd7, 32'h1111_0000 + k, TB'(k));
            settle;
            checks++;
            if (wb_valid !== 2'b01 || wb_data[31:0] !== 32'h1111_0000 + k - 1) begin
                failures++; $display("FAIL pushpop_k%0d vld=%b data=%h exp vld=01 data=%h", k, wb_valid, wb_data[31:0], 32'h1111_0000 + k - 1);
            end
            checks++;
            if (dut.r_cnt[1] !== 2'd1 || fu_ready[1] !== 1'b1) begin
                failures++; $display("FAIL pushpop_count_k%0d cnt=%0d ready=%b exp cnt=1 ready=1", k, dut.r_cnt[1], fu_ready[1]);
            end
        end
        tick;
        idle;
        settle;
        checks++;
        if (wb_valid !== 2'b01 || wb_data[31:0] !== 32'h1111_0004 || dut.r_cnt[1] !== 2'd1) begin
            failures++; $display("FAIL pushpop_last vld=%b data=%h cnt=%0d exp vld=01 data=11110004 cnt=1", wb_valid, wb_data[31:0], dut.r_cnt[1]);
        end
        tick;
        settle;
        checks++;
        if (wb_valid !== 2'b00) begin
            failures++; $display("FAIL pushpop_drained got=%b exp=00", wb_valid);
        end
    endtask

    // rr_ptr is 2 here (FU1 served last), so the cycle before flush serves FU2/FU3 and leaves 5 entries.
    task automatic test_flush;
        tick;
        for (int i = 0; i < FUN; i++) drive(i, RA'(i), 32'hF000_0000 + i, TB'(i));
        settle;
        tick;
        idle;
        for (int i = 0; i < 3; i++) drive(i, RA'(i), 32'hF100_0000 + i, TB'(i));
        settle;
        checks++;
        if (wb_valid !== 2'b11 || wb_data[31:0] !== 32'hF000_0002 || wb_data[63:32] !== 32'hF000_0003) begin
            failures++; $display("FAIL flush_prefill vld=%b data=%h exp vld=11 data=f0000003f0000002", wb_valid, wb_data);
        end
        tick;
        for (int i = 0; i < FUN; i++) drive(i, RA'(i), 32'hEEEE_0000 + i, TB'(i));
        flush = 1'b1;
        settle;
        checks++;
        if (wb_valid !== 2'b00 || wb_data !== '0) begin
            failures++; $display("FAIL flush_cycle_wb vld=%b data=%h exp vld=00 data=0", wb_valid, wb_data);
        end
        checks++;
        if (fu_ready !== 4'b1100) begin
            failures++; $display("FAIL flush_cycle_ready got=%b exp=1100", fu_ready);
        end
        tick;
        flush = 1'b0;
        idle;
        settle;
        checks++;
        if (fu_ready !== 4'b1111 || wb_valid !== 2'b00) begin
            failures++; $display("FAIL flush_after ready=%b vld=%b exp ready=1111 vld=00", fu_ready, wb_valid);
        end
        for (int i = 0; i < FUN; i++) drive(i, RA'(i), 32'h7700_0000 + i, TB'(i));
        tick;
        idle;
        settle;
        checks++;
        if (wb_valid !== 2'b11 || wb_data[31:0] !== 32'h7700_0000 || wb_data[63:32] !== 32'h7700_0001) begin
            failures++; $display("FAIL flush_rr_restart vld=%b data=%h exp vld=11 data=7700000177000000", wb_valid, wb_data);
        end
        tick;
        tick;
        settle;
    endtask

    task automatic test_reset_mid;
        tick;
        for (int i = 0; i < 3; i++) drive(i, RA'(i), 32'h5A5A_0000 + i, TB'(i));
        settle;
        tick;
        idle;
        settle;
        checks++;
        if (wb_valid !== 2'b11) begin
            failures++; $display("FAIL midrst_before got=%b exp=11", wb_valid);
        end
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (wb_valid !== 2'b00 || fu_ready !== 4'b1111 || wb_data !== '0) begin
            failures++; $display("FAIL midrst_async vld=%b ready=%b data=%h exp vld=00 ready=1111 data=0", wb_valid, fu_ready, wb_data);
        end
        tick;
        rst_n = 1'b0;
        settle;
        checks++;
        if (wb_valid !== 2'b00) begin
            failures++; $display("FAIL midrst_after1 got=%b exp=00", wb_valid);
        end
        tick;
        settle;
        checks++;
        if (wb_valid !== 2'b00) begin
            failures++; $display("FAIL midrst_after2 got=%b exp=00", wb_valid);
        end
    endtask

    initial begin
        test_reset;
        test_all_four;
        test_backpressure;
        test_single;
        test_push_pop;
        test_flush;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
